mult_response_checker: RTL

- Synthesizable response-side companion to the c6288 stimulus bench.
- Takes each applied 32-bit operand vector and computes the golden 16x16 product.
- After a programmable sample delay, it compares the golden product against the DUT response.
- Accumulates vector/mismatch counts and first-failure data so aging runs can be self-checked on-chip instead of by post-processing output files.

---
 rtl/mult_response_checker.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/mult_response_checker.sv
// On-chip response checker for a 16x16 multiplier: golden product, delayed compare, run statistics.
// Optional MISR signature over the checked responses is enabled with `define RESP_MISR_EN.
module mult_response_checker #(
    parameter int unsigned SAMPLE_DLY = 2,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] total_vec,
    input  logic             vec_valid,
    input  logic [31:0]      vec_data,
    input  logic [31:0]      resp_data,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [31:0]      first_err_xor,
    output logic [31:0]      signature
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] total_q;
    logic [CNT_W-1:0] accepted_q;
    logic [CNT_W-1:0] vec_count_q;
    logic [CNT_W-1:0] err_count_q;
    logic [CNT_W-1:0] first_err_idx_q;
    logic [31:0]      first_err_xor_q;
    logic             done_q;
    logic             pass_q;

    logic [SAMPLE_DLY-1:0] pipe_vld_q;
    logic [31:0]           pipe_exp_q [SAMPLE_DLY];

    logic        accept;
    logic        check;
    logic        mismatch;
    logic        start_ok;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] golden;
    logic [31:0] resp_xor;

    assign op_a     = {16'h0000, vec_data[31:16]};
    assign op_b     = {16'h0000, vec_data[15:0]};
    assign golden   = op_a * op_b;

    assign accept   = vec_valid && (state_q == StRun) && (accepted_q < total_q);
    assign check    = pipe_vld_q[SAMPLE_DLY-1];
    assign resp_xor = resp_data ^ pipe_exp_q[SAMPLE_DLY-1];
    assign mismatch = check && (resp_xor != 32'h0);
    assign start_ok = start && ((state_q == StIdle) || (state_q == StDone));

    // Expected-value delay line; the last stage lines up with the DUT response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld_q <= '0;
            for (int i = 0; i < SAMPLE_DLY; i++) begin
                pipe_exp_q[i] <= 32'h0;
            end
        end else begin
            pipe_vld_q[0] <= accept;
            if (accept) begin
                pipe_exp_q[0] <= golden;
            end
            for (int i = 1; i < SAMPLE_DLY; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_exp_q[i] <= pipe_exp_q[i-1];
            end
        end
    end

    // Run control and statistics; a start never coincides with a check (pipeline empty).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            total_q         <= '0;
            accepted_q      <= '0;
            vec_count_q     <= '0;
            err_count_q     <= '0;
            first_err_idx_q <= '0;
            first_err_xor_q <= 32'h0;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
        end else begin
            if (accept) begin
                accepted_q <= accepted_q + CNT_W'(1);
            end
            if (check) begin
                vec_count_q <= vec_count_q + CNT_W'(1);
                if (mismatch) begin
                    if (err_count_q != '1) begin
                        err_count_q <= err_count_q + CNT_W'(1);
                    end
                    if (err_count_q == '0) begin
                        first_err_idx_q <= vec_count_q;
                        first_err_xor_q <= resp_xor;
                    end
                end
            end

            case (state_q)
                StIdle, StDone: begin
                    if (start_ok) begin
                        state_q         <= StRun;
                        total_q         <= total_vec;
                        accepted_q      <= '0;
                        vec_count_q     <= '0;
                        err_count_q     <= '0;
                        first_err_idx_q <= '0;
                        first_err_xor_q <= 32'h0;
                        done_q          <= 1'b0;
                        pass_q          <= 1'b0;
                    end
                end
                StRun: begin
                    if (accepted_q == total_q) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (pipe_vld_q == '0) begin
                        state_q <= StDone;
                        done_q  <= 1'b1;
                        pass_q  <= (err_count_q == '0);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef RESP_MISR_EN
    logic [31:0] sig_q;
    logic        sig_fb;

    assign sig_fb = sig_q[31] ^ sig_q[21] ^ sig_q[1] ^ sig_q[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= 32'h0;
        end else if (start_ok) begin
            sig_q <= 32'hFFFF_FFFF;
        end else if (check) begin
            sig_q <= {sig_q[30:0], sig_fb} ^ resp_data;
        end
    end

    assign signature = sig_q;
`else
    assign signature = 32'h0;
`endif

    assign busy          = (state_q == StRun) || (state_q == StDrain);
    assign done          = done_q;
    assign pass          = pass_q;
    assign vec_count     = vec_count_q;
    assign err_count     = err_count_q;
    assign first_err_idx = first_err_idx_q;
    assign first_err_xor = first_err_xor_q;

endmodule
